stack_engine: RTL and testbench
===============================

// Module: stack_engine
// PURPOSE
//   Parametrised operand stack for the stack calculator datapath. It generalises the
//   fixed 4-bit push/pop register: configurable word width and depth, encoded stack ops
//   (DUP/SWAP/OVER/REPLACE), occupancy count, full/empty flags and sticky error flags.
//   It sits between the stack_cpu decoder (op source) and the ALU (top/second operands).
// PARAMETERS
//   WIDTH  4  data word width, bits (>=1)
//   DEPTH  8  number of stack entries (>=2)
// PORTS
//   clk          in   1              single clock, rising edge
//   rst          in   1              synchronous reset, active-low (0 = reset)
//   op_valid     in   1              op strobe; op ignored (NOP) when 0
//   op           in   3              stack_pkg::stack_op_e
//   in_word      in   WIDTH          data for PUSH / REPLACE
//   clr_err      in   1              clears ovf/udf sticky flags
//   top_word     out  WIDTH          entry at sp-1; 0 when empty
//   second_word  out  WIDTH          entry at sp-2; 0 when count<2
//   count        out  $clog2(DEPTH+1) occupancy, 0..DEPTH
//   empty, full  out  1              count==0 / count==DEPTH
//   ovf, udf     out  1              sticky overflow / underflow flags
//   op_done      out  1              pulse: previous-cycle op was legal and executed
// BEHAVIOUR
//   - All state updates on rising clk; outputs are functions of registered state, so
//     the effect of an op taken at edge N is visible after edge N (one-cycle latency).
//   - Reset (rst==0 at an edge): count=0, all entries=0, ovf=udf=op_done=0; top/second=0,
//     empty=1, full=0. Reset overrides op_valid and clr_err in the same cycle.
//   - Ops (need = legality condition; illegal op leaves stack unchanged):
//       NOP 000: no change.
//       PUSH 001: need !full; mem[sp]<=in_word, count+1.
//       POP 010: need count>=1; count-1 (popped entry need not be cleared).
//       DUP 011: need count>=1 && !full; push copy of top.
//       SWAP 100: need count>=2; exchange top and second.
//       OVER 101: need count>=2 && !full; push copy of second.
//       REPLACE 110: need count>=1; top<=in_word, count unchanged (ALU write-back).
//       111: reserved, treated as NOP, no flag.
//   - Illegal due to full -> ovf<=1; due to insufficient count -> udf<=1. Both can never
//     set from one op; DUP/OVER on empty sets udf (count check wins over full check).
//   - op_done<=1 for one cycle on each legal non-NOP op; 0 otherwise.
//   - clr_err clears ovf/udf; if an error occurs in the same cycle, the new error wins (flag=1).
//   - No wrap-around: count saturates in range 0..DEPTH by construction.
//   - Reads of top/second for unoccupied slots are forced to 0 (never stale data).
// CONFIGURATION
//   STACK_PEEK_EN defined: adds ports peek_idx (in, $clog2(DEPTH)) and peek_word (out,
//     WIDTH); peek_word = entry at depth peek_idx below top (0 = top), combinational,
//     0 when peek_idx>=count. Undefined: ports absent, no extra logic.
// STRUCTURE
//   - Package stack_pkg: typedef enum logic[2:0] stack_op_e {OP_NOP, OP_PUSH, OP_POP,
//     OP_DUP, OP_SWAP, OP_OVER, OP_REPLACE}; localparam STACK_OP_W=3.
//   - Single module; no sub-module. Storage is a DEPTH x WIDTH register array with a count
//     pointer (not a shift chain), write-port logic selected by decoded op.
// TESTING  (WIDTH=4, DEPTH=8 unless stated)
//   1. Reset: rst=0 one edge -> count=0, empty=1, top=second=0, ovf=udf=0.
//   2. PUSH 3, PUSH 5, SWAP, OVER -> top=5, second=3, count=3, op_done each cycle.
//   3. 8x PUSH 0xA, 9th PUSH 0xF -> full=1, ovf=1, top=0xA, count=8; clr_err -> ovf=0.
//   4. Empty: POP -> udf=1, count=0; DUP -> udf stays 1, ovf=0, op_done=0.
//   5. PUSH 7, REPLACE 2 with clr_err and rst=0 same cycle -> all reset values.
//   6. STACK_PEEK_EN: PUSH 1,2,3; peek_idx=2 -> peek_word=1; peek_idx=3 -> 0.

Source files
------------

// File: rtl/stack_pkg.sv
// ============================================================================
//  Module   : stack_pkg
//  Brief    : Shared op encoding for the operand stack engine.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package stack_pkg;

    localparam int STACK_OP_W = 3;

    // Encoding 3'b111 is reserved and behaves as a NOP
    typedef enum logic [STACK_OP_W-1:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_DUP     = 3'd3,
        OP_SWAP    = 3'd4,
        OP_OVER    = 3'd5,
        OP_REPLACE = 3'd6
    } stack_op_e;

endpackage

`default_nettype wire

// File: rtl/stack_engine.sv
// ============================================================================
//  Module   : stack_engine
//  Brief    : Parametrised operand stack with encoded ops, occupancy and
//             sticky overflow/underflow flags. Optional peek port under
//             macro STACK_PEEK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stack_engine
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    input  logic [STACK_OP_W-1:0]      op,
    input  logic [WIDTH-1:0]           in_word,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           top_word,
    output logic [WIDTH-1:0]           second_word,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       udf,
    output logic                       op_done
`ifdef STACK_PEEK_EN
    ,
    input  logic [$clog2(DEPTH)-1:0]   peek_idx,
    output logic [WIDTH-1:0]           peek_word
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_udf;
    logic             r_op_done;

    stack_op_e        w_op;
    logic [IW-1:0]    w_sp;
    logic [IW-1:0]    w_top_idx;
    logic [IW-1:0]    w_sec_idx;
    logic             w_has1;
    logic             w_has2;
    logic             w_full;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_second;

    logic             w_exec;
    logic             w_ovf_err;
    logic             w_udf_err;
    logic             w_wa_en;
    logic [IW-1:0]    w_wa_idx;
    logic [WIDTH-1:0] w_wa_data;
    logic             w_wb_en;
    logic [IW-1:0]    w_wb_idx;
    logic [WIDTH-1:0] w_wb_data;
    logic [CW-1:0]    w_count_nxt;

    // Index arithmetic is modulo 2**IW, which stays correct when DEPTH is a
    // power of two and count==DEPTH truncates to 0.
    assign w_op      = stack_op_e'(op);
    assign w_sp      = r_count[IW-1:0];
    assign w_top_idx = w_sp - IW'(1);
    assign w_sec_idx = w_sp - IW'(2);
    assign w_has1    = (r_count != '0);
    assign w_has2    = (r_count >= CW'(2));
    assign w_full    = (r_count == c_full_cnt);
    assign w_top     = w_has1 ? r_mem[w_top_idx] : '0;
    assign w_second  = w_has2 ? r_mem[w_sec_idx] : '0;

    always_comb begin
        w_exec      = 1'b0;
        w_ovf_err   = 1'b0;
        w_udf_err   = 1'b0;
        w_wa_en     = 1'b0;
        w_wa_idx    = w_sp;
        w_wa_data   = in_word;
        w_wb_en     = 1'b0;
        w_wb_idx    = w_sec_idx;
        w_wb_data   = w_top;
        w_count_nxt = r_count;
        if (op_valid) begin
            // Count checks come first so DUP/OVER on an empty stack report underflow
            case (w_op)
                OP_PUSH: begin
                    if (w_full) begin
                        w_ovf_err = 1'b1;
                    end else begin
                        w_exec      = 1'b1;
                        w_wa_en     = 1'b1;
                        w_count_nxt = r_count + CW'(1);
                    end
                end
                OP_POP: begin
                    if (!w_has1) begin
                        w_udf_err = 1'b1;
                    end else begin
                        w_exec      = 1'b1;
                        w_count_nxt = r_count - CW'(1);
                    end
                end
                OP_DUP: begin
                    if (!w_has1) begin
                        w_udf_err = 1'b1;
                    end else if (w_full) begin
                        w_ovf_err = 1'b1;
                    end else begin
                        w_exec      = 1'b1;
                        w_wa_en     = 1'b1;
                        w_wa_data   = w_top;
                        w_count_nxt = r_count + CW'(1);
                    end
                end
                OP_SWAP: begin
                    if (!w_has2) begin
                        w_udf_err = 1'b1;
                    end else begin
                        w_exec    = 1'b1;
                        w_wa_en   = 1'b1;
                        w_wa_idx  = w_top_idx;
                        w_wa_data = w_second;
                        w_wb_en   = 1'b1;
                    end
                end
                OP_OVER: begin
                    if (!w_has2) begin
                        w_udf_err = 1'b1;
                    end else if (w_full) begin
                        w_ovf_err = 1'b1;
                    end else begin
                        w_exec      = 1'b1;
                        w_wa_en     = 1'b1;
                        w_wa_data   = w_second;
                        w_count_nxt = r_count + CW'(1);
                    end
                end
                OP_REPLACE: begin
                    if (!w_has1) begin
                        w_udf_err = 1'b1;
                    end else begin
                        w_exec   = 1'b1;
                        w_wa_en  = 1'b1;
                        w_wa_idx = w_top_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wa_en && (w_wa_idx == IW'(i))) begin
                    r_mem[i] <= w_wa_data;
                end else if (w_wb_en && (w_wb_idx == IW'(i))) begin
                    r_mem[i] <= w_wb_data;
                end
            end
        end
    end

    // A new error in the same cycle as clr_err wins
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_op_done <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_ovf     <= w_ovf_err | (r_ovf & ~clr_err);
            r_udf     <= w_udf_err | (r_udf & ~clr_err);
            r_op_done <= w_exec;
        end
    end

    assign top_word    = w_top;
    assign second_word = w_second;
    assign count       = r_count;
    assign empty       = !w_has1;
    assign full        = w_full;
    assign ovf         = r_ovf;
    assign udf         = r_udf;
    assign op_done     = r_op_done;

`ifdef STACK_PEEK_EN
    logic          w_peek_ok;
    logic [IW-1:0] w_peek_pos;

    assign w_peek_ok  = (CW'(peek_idx) < r_count);
    assign w_peek_pos = w_top_idx - peek_idx;
    assign peek_word  = w_peek_ok ? r_mem[w_peek_pos] : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stack_engine.sv
// ============================================================================
//  Module   : tb_stack_engine
//  Brief    : Randomised self-checking bench for stack_engine against a
//             queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stack_engine;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             op_valid;
    logic [2:0]       op;
    logic [WIDTH-1:0] in_word;
    logic             clr_err;
    logic [WIDTH-1:0] top_word;
    logic [WIDTH-1:0] second_word;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;
    logic             op_done;
`ifdef STACK_PEEK_EN
    logic [$clog2(DEPTH)-1:0] peek_idx;
    logic [WIDTH-1:0]         peek_word;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] m_stk[$];
    bit               m_ovf;
    bit               m_udf;
    bit               m_done;

    always #5 clk = ~clk;

    stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op          (op),
        .in_word     (in_word),
        .clr_err     (clr_err),
        .top_word    (top_word),
        .second_word (second_word),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .ovf         (ovf),
        .udf         (udf),
        .op_done     (op_done)
`ifdef STACK_PEEK_EN
        ,
        .peek_idx    (peek_idx),
        .peek_word   (peek_word)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model applies one clock edge worth of behaviour
    task automatic model_step(input bit r, input bit v, input int o,
                              input logic [WIDTH-1:0] w, input bit c);
        int  n;
        bit  eo;
        bit  eu;
        bit  ok;
        logic [WIDTH-1:0] t;
        n  = m_stk.size();
        eo = 0; eu = 0; ok = 0;
        if (!r) begin
            m_stk.delete();
            m_ovf = 0; m_udf = 0; m_done = 0;
            return;
        end
        if (v) begin
            case (o)
                1: if (n == DEPTH) eo = 1; else begin m_stk.push_back(w); ok = 1; end
                2: if (n < 1) eu = 1; else begin void'(m_stk.pop_back()); ok = 1; end
                3: if (n < 1) eu = 1; else if (n == DEPTH) eo = 1;
                   else begin m_stk.push_back(m_stk[n-1]); ok = 1; end
                4: if (n < 2) eu = 1;
                   else begin t = m_stk[n-1]; m_stk[n-1] = m_stk[n-2]; m_stk[n-2] = t; ok = 1; end
                5: if (n < 2) eu = 1; else if (n == DEPTH) eo = 1;
                   else begin m_stk.push_back(m_stk[n-2]); ok = 1; end
                6: if (n < 1) eu = 1; else begin m_stk[n-1] = w; ok = 1; end
                default: ;
            endcase
        end
        m_ovf  = eo | (m_ovf & !c);
        m_udf  = eu | (m_udf & !c);
        m_done = ok;
    endtask

    task automatic compare_all(input string pfx);
        int n;
        n = m_stk.size();
        check({pfx, ".count"},   int'(count),       n);
        check({pfx, ".top"},     int'(top_word),    (n >= 1) ? int'(m_stk[n-1]) : 0);
        check({pfx, ".second"},  int'(second_word), (n >= 2) ? int'(m_stk[n-2]) : 0);
        check({pfx, ".empty"},   int'(empty),       int'(n == 0));
        check({pfx, ".full"},    int'(full),        int'(n == DEPTH));
        check({pfx, ".ovf"},     int'(ovf),         int'(m_ovf));
        check({pfx, ".udf"},     int'(udf),         int'(m_udf));
        check({pfx, ".op_done"}, int'(op_done),     int'(m_done));
    endtask

    task automatic cycle(input string pfx, input bit r, input bit v, input int o,
                         input logic [WIDTH-1:0] w, input bit c);
        rst      = r;
        op_valid = v;
        op       = 3'(o);
        in_word  = w;
        clr_err  = c;
        @(posedge clk);
        model_step(r, v, o, w, c);
        #1;
        compare_all(pfx);
    endtask

    initial begin
        int o;
        bit r, v, c;
        rst = 1'b0; op_valid = 1'b0; op = '0; in_word = '0; clr_err = 1'b0;
`ifdef STACK_PEEK_EN
        peek_idx = '0;
`endif
        m_ovf = 0; m_udf = 0; m_done = 0;

        cycle("reset", 0, 0, 0, 4'h0, 0);
        check("reset.empty_const", int'(empty), 1);

        cycle("t2.push3", 1, 1, 1, 4'h3, 0);
        cycle("t2.push5", 1, 1, 1, 4'h5, 0);
        cycle("t2.swap",  1, 1, 4, 4'h0, 0);
        cycle("t2.over",  1, 1, 5, 4'h0, 0);
        check("t2.final_top", int'(top_word), 5);
        check("t2.final_second", int'(second_word), 3);

        cycle("t3.rst", 0, 0, 0, 4'h0, 0);
        for (int i = 0; i < DEPTH; i++) cycle("t3.push", 1, 1, 1, 4'hA, 0);
        cycle("t3.push9", 1, 1, 1, 4'hF, 0);
        check("t3.ovf_set", int'(ovf), 1);
        check("t3.top_keep", int'(top_word), 10);
        cycle("t3.dup_full", 1, 1, 3, 4'h0, 0);
        cycle("t3.clr", 1, 0, 0, 4'h0, 1);
        check("t3.ovf_clr", int'(ovf), 0);

        cycle("t4.rst", 0, 0, 0, 4'h0, 0);
        cycle("t4.pop", 1, 1, 2, 4'h0, 0);
        cycle("t4.dup", 1, 1, 3, 4'h0, 0);
        check("t4.udf_held", int'(udf), 1);
        cycle("t4.clr_and_err", 1, 1, 4, 4'h0, 1);
        cycle("t4.rsvd", 1, 1, 7, 4'h0, 1);

        cycle("t5.push7", 1, 1, 1, 4'h7, 0);
        cycle("t5.rst_rep", 0, 1, 6, 4'h2, 1);

`ifdef STACK_PEEK_EN
        cycle("t6.push1", 1, 1, 1, 4'h1, 0);
        cycle("t6.push2", 1, 1, 1, 4'h2, 0);
        cycle("t6.push3", 1, 1, 1, 4'h3, 0);
        peek_idx = 2; #1;
        check("t6.peek2", int'(peek_word), 1);
        peek_idx = 3; #1;
        check("t6.peek3", int'(peek_word), 0);
        peek_idx = 0; #1;
        check("t6.peek0", int'(peek_word), 3);
`endif

        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) != 0);
            v = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 7) == 0);
            // Alternate push-heavy and pop-heavy phases to reach both boundaries
            if (((i / 60) % 2) == 0 && $urandom_range(0, 1) == 1) o = 1;
            else if (((i / 60) % 2) == 1 && $urandom_range(0, 1) == 1) o = 2;
            else o = int'($urandom_range(0, 7));
            cycle("rand", r, v, o, 4'($urandom_range(0, 15)), c);
`ifdef STACK_PEEK_EN
            peek_idx = 3'($urandom_range(0, DEPTH-1)); #1;
            check("rand.peek", int'(peek_word),
                  (int'(peek_idx) < m_stk.size()) ? int'(m_stk[m_stk.size()-1-int'(peek_idx)]) : 0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
